// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, field indices and helpers for the BCD HH:MM:SS timer
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam int H10_IDX = 20;
  localparam int H1_IDX  = 16;
  localparam int M10_IDX = 12;
  localparam int M1_IDX  = 8;
  localparam int S10_IDX = 4;
  localparam int S1_IDX  = 0;

  typedef enum logic [1:0] {
    STOP    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Both digits decimal and the pair value below the field modulus.
  function automatic logic bcd_pair_valid(input bcd_t tens, input bcd_t ones, input int mod);
    return (tens <= 4'd9) && (ones <= 4'd9) && ((int'(tens) * 10 + int'(ones)) < mod);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit loadable up/down BCD counter with modulus MOD
module bcd_mod_counter
  import timer_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       en,
  input  logic       down,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       co
);

  localparam bcd_t TOP_T = bcd_t'((MOD - 1) / 10);
  localparam bcd_t TOP_O = bcd_t'((MOD - 1) % 10);

  logic at_top;
  logic at_zero;

  assign at_top  = (tens == TOP_T) && (ones == TOP_O);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);
  // Carry/borrow is combinational so the next stage advances on the same edge.
  assign co      = en && (down ? at_zero : at_top);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (en) begin
      if (down) begin
        if (at_zero) begin
          tens <= TOP_T;
          ones <= TOP_O;
        end else if (ones == 4'd0) begin
          tens <= tens - 4'd1;
          ones <= 4'd9;
        end else begin
          ones <= ones - 4'd1;
        end
      end else begin
        if (at_top) begin
          tens <= 4'd0;
          ones <= 4'd0;
        end else if (ones == 4'd9) begin
          tens <= tens + 4'd1;
          ones <= 4'd0;
        end else begin
          ones <= ones + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_hms_timer.sv
// rtl/bcd_hms_timer.sv - prescaled HH:MM:SS BCD up/down timer with load check and expiry
module bcd_hms_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1,
  parameter int HOUR_MOD = 24
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        run,
  input  logic        mode_down,
  input  logic        load,
  input  logic [23:0] set_time,
  output logic [23:0] time_bcd,
  output logic        tick_out,
  output logic        carry_out,
  output logic        done,
  output logic        load_err
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  state_t        state;
  logic [PW-1:0] presc;
  logic          load_ok;
  logic          cnt_load;
  logic          tick;
  logic          at_zero;
  logic          at_one;
  logic          adv;
  logic          expire;
  logic          sec_co;
  logic          min_co;
  logic          hr_co;
  logic [3:0]    h10, h1, m10, m1, s10, s1;

  assign load_ok = bcd_pair_valid(set_time[H10_IDX +: 4], set_time[H1_IDX +: 4], HOUR_MOD) &&
                   bcd_pair_valid(set_time[M10_IDX +: 4], set_time[M1_IDX +: 4], 60) &&
                   bcd_pair_valid(set_time[S10_IDX +: 4], set_time[S1_IDX +: 4], 60);
  assign cnt_load = load && load_ok;

  // A tick is only honoured while run is still high; a same-cycle drop discards it.
  assign tick    = (state == RUN) && run && (presc == PW'(DIV - 1));
  assign at_zero = (time_bcd == 24'h00_00_00);
  assign at_one  = (time_bcd == 24'h00_00_01);
  assign adv     = tick && !load && !(mode_down && at_zero);
  assign expire  = mode_down && (at_zero || at_one);

  assign time_bcd = {h10, h1, m10, m1, s10, s1};

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk       (clk),
    .reset_p   (reset_p),
    .en        (adv),
    .down      (mode_down),
    .load      (cnt_load),
    .load_tens (set_time[S10_IDX +: 4]),
    .load_ones (set_time[S1_IDX +: 4]),
    .tens      (s10),
    .ones      (s1),
    .co        (sec_co)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk       (clk),
    .reset_p   (reset_p),
    .en        (sec_co),
    .down      (mode_down),
    .load      (cnt_load),
    .load_tens (set_time[M10_IDX +: 4]),
    .load_ones (set_time[M1_IDX +: 4]),
    .tens      (m10),
    .ones      (m1),
    .co        (min_co)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk       (clk),
    .reset_p   (reset_p),
    .en        (min_co),
    .down      (mode_down),
    .load      (cnt_load),
    .load_tens (set_time[H10_IDX +: 4]),
    .load_ones (set_time[H1_IDX +: 4]),
    .tens      (h10),
    .ones      (h1),
    .co        (hr_co)
  );

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= STOP;
      presc     <= '0;
      tick_out  <= 1'b0;
      carry_out <= 1'b0;
      done      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      tick_out  <= 1'b0;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        presc <= '0;
        if (load_ok) begin
          done  <= 1'b0;
          state <= run ? RUN : STOP;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        case (state)
          STOP: begin
            presc <= '0;
            if (run) state <= RUN;
          end
          RUN: begin
            if (!run) begin
              state <= STOP;
              presc <= '0;
            end else if (tick) begin
              presc     <= '0;
              tick_out  <= 1'b1;
              carry_out <= hr_co && !mode_down;
              if (expire) begin
                state <= EXPIRED;
                done  <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          EXPIRED: presc <= '0;
          default: begin
            state <= STOP;
            presc <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bcd_hms_timer.md
# bcd_hms_timer

Parametrised HH:MM:SS BCD timebase and counter for the watch/stopwatch/timer family. An internal prescaler derives a one-cycle tick from the system clock, and a three-stage loadable up/down BCD counter runs off that tick. The block adds run/stop control, up/down mode, loading with validity checking, terminal-count expiry and a day-wrap carry. It sits between the system clock and the FND display/mode-control logic, and replaces the chain of individual fixed dividers and 60-counters.

## Interface
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1, count rate. DIV = CLK_HZ/TICK_HZ; must be an integer ≥ 2.
- HOUR_MOD, 24, hour modulus; legal range 1..100.
- clk  in  1  system clock; all logic on its rising edge.
- reset_p  in  1  reset; synchronous, active-high.
- run  in  1  level; 1 = count, 0 = hold.
- mode_down  in  1  0 = count up, 1 = count down.
- load  in  1  one-cycle strobe that loads set_time.
- set_time  in  24  BCD {h10,h1,m10,m1,s10,s1}, 4 bits per digit.
- time_bcd  out  24  current time, same packing as set_time.
- tick_out  out  1  one-cycle pulse, coincident with each new time_bcd value.
- carry_out  out  1  one-cycle pulse on up-mode wrap to 00:00:00.
- done  out  1  level; down-count expired.
- load_err  out  1  one-cycle pulse; load rejected.

## Operation
- Reset: time_bcd=0, prescaler=0, state=STOP, tick_out=0, carry_out=0, done=0, load_err=0. Reset overrides every other input.
- Prescaler:
  - Counts 0..DIV-1 only while state=RUN; internal tick when value = DIV-1, then returns to 0.
  - Held at 0 in STOP and EXPIRED, and cleared by any load (accepted or rejected). The first tick therefore arrives exactly DIV cycles after RUN begins.
- FSM states: STOP, RUN, EXPIRED.
  - STOP→RUN when run=1. RUN→STOP when run=0; prescaler clears.
  - RUN→EXPIRED on a tick with mode_down=1 that produces 00:00:00.
  - RUN→EXPIRED on a tick with mode_down=1 while time is already 00:00:00; no decrement occurs.
  - EXPIRED is left only via an accepted load or reset.
- Load (priority below reset, above tick):
  - Valid load requires every digit ≤ 9, s10 ≤ 5, m10 ≤ 5, and hour < HOUR_MOD.
  - Valid load: time_bcd ← set_time, done ← 0, state ← RUN if run else STOP.
  - Invalid load: time_bcd and state unchanged, load_err pulses.
- Up count: s1 through s10 (mod 60), carry into minutes (mod 60), carry into hours (mod HOUR_MOD). HOUR_MOD-1:59:59 → 00:00:00 with carry_out.
- Down count: borrow chain mirroring up count, with seconds 00 → 59 borrowing from minutes. The counter never wraps below 00:00:00.
- A mode_down change while running takes effect at the next tick. A change while in EXPIRED has no effect.
- run=0 and a tick in the same cycle: the tick is dropped.

## Timing
- Internal tick at edge N: time_bcd updates at edge N. tick_out, carry_out and the rise of done are high in the cycle following edge N, aligned with the new value.
- Load at edge N: time_bcd is valid after edge N, and load_err (if any) is high for the cycle following edge N.
- done rises with the tick_out of the expiring count and clears on the edge that accepts the next load.
- tick_out pulse spacing in continuous RUN: exactly DIV cycles.

## Structure
- Package timer_pkg holds:
  - a 4-bit BCD digit typedef;
  - field index constants for h10..s1 within the 24-bit word;
  - the state enum {STOP, RUN, EXPIRED};
  - the function bcd_pair_valid(tens, ones, mod).
- Sub-module bcd_mod_counter:
  - a two-digit BCD counter with parameter MOD;
  - inputs en, down, load, load value; outputs digits and a registered-free carry/borrow-out (combinational terminal-count AND en).
  - Instantiated three times: 60, 60, HOUR_MOD.
- Top level holds the prescaler, FSM, validity check and output pulse registers.

## Test plan
Run all scenarios with CLK_HZ=10, TICK_HZ=1 (DIV=10) and HOUR_MOD=24.
- Reset then run=1, up mode → first tick_out 10 cycles after run. After 3 ticks time_bcd=00:00:03; all other outputs 0.
- Load 23:59:58, run up → after 2 ticks time_bcd=00:00:00 with carry_out high for 1 cycle, aligned with tick_out.
- Load 00:01:00, mode_down=1, run → after 1 tick 00:00:59. After 60 ticks 00:00:00 with done=1; time holds and tick_out stops. Loading 00:00:05 clears done.
- Load 24:00:00, and separately 00:6A:00 → load_err pulses each time; time_bcd and state unchanged.
- In RUN, assert load (12:34:56) on the cycle the prescaler is at DIV-1 → time_bcd=12:34:56, no increment, next tick 10 cycles later gives 12:34:57.
- Assert reset_p mid-count at 05:06:07 with done=0 → next cycle all outputs zero and state=STOP. Drop run for 25 cycles → no ticks occur, and counting resumes 10 cycles after run returns.
